// File: rtl/stream_fifo_if.sv
// rtl/stream_fifo_if.sv - valid/ready stream bundle used on both sides of stream_fifo
interface stream_fifo_if #(
    parameter int WIDTH = 256
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    // Source side drives valid/data, sink side drives ready.
    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - parametrised valid/ready FIFO with FWFT or registered output
module stream_fifo #(
    parameter int WIDTH     = 256,
    parameter int DEPTH     = 4,
    parameter int FWFT      = 1,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    localparam int CAP      = DEPTH + ((FWFT != 0) ? 0 : 1),
    localparam int CW       = $clog2(CAP + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush_i,
    input  logic          hw_clear_i,
    stream_fifo_if.slave  in_if,
    stream_fifo_if.master out_if,
    output logic [CW-1:0] count_o,
    output logic [CW-1:0] high_water_o,
    output logic          almost_full_o,
    output logic          almost_empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MW = $clog2(DEPTH + 1);

    generate
        if (DEPTH < 2 || WIDTH < 1) begin : g_bad_params
            $error("stream_fifo: DEPTH must be >= 2 and WIDTH >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [MW-1:0]    mcount_q, mcount_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    hw_q, hw_d;
    logic             ovalid_q, ovalid_d;
    logic [WIDTH-1:0] odata_q, odata_d;

    logic in_ready;
    logic out_valid;
    logic accept;
    logic pop;
    logic mem_rd;

    // Explicit wrap so non-power-of-2 depths address only valid entries.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A full memory refuses writes even when a pop happens in the same cycle.
    assign in_ready  = (mcount_q < MW'(DEPTH));
    assign out_valid = (FWFT != 0) ? (mcount_q != '0) : ovalid_q;
    assign accept    = in_if.valid && in_ready && !flush_i;
    assign pop       = out_valid && out_if.ready && !flush_i;
    // In registered mode the memory is read whenever the output register is free or draining.
    assign mem_rd    = (FWFT != 0) ? pop
                                   : ((!ovalid_q || pop) && (mcount_q != '0) && !flush_i);

    assign in_if.ready    = in_ready;
    assign out_if.valid   = out_valid;
    assign out_if.data    = (FWFT != 0) ? mem[rd_ptr_q] : odata_q;
    assign count_o        = count_q;
    assign high_water_o   = hw_q;
    assign almost_full_o  = (int'(count_q) >= AF_THRESH);
    assign almost_empty_o = (int'(count_q) <= AE_THRESH);

    // Next-state: flush wins over any handshake; otherwise advance pointers and counts.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mcount_d = mcount_q;
        count_d  = count_q;
        ovalid_d = ovalid_q;
        odata_d  = odata_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            mcount_d = '0;
            count_d  = '0;
            ovalid_d = 1'b0;
        end else begin
            if (accept) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (mem_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
            mcount_d = mcount_q + MW'(accept) - MW'(mem_rd);
            count_d  = count_q + CW'(accept) - CW'(pop);
            if (FWFT == 0) begin
                if (mem_rd) begin
                    ovalid_d = 1'b1;
                    odata_d  = mem[rd_ptr_q];
                end else if (pop) begin
                    ovalid_d = 1'b0;
                end
            end
        end
        // With flush, count_d is 0, so a coincident hw_clear leaves high_water at 0.
        hw_d = hw_q;
        if (hw_clear_i) begin
            hw_d = count_d;
        end else if (count_d > hw_q) begin
            hw_d = count_d;
        end
    end

    // Control state; asynchronous reset discards everything immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mcount_q <= '0;
            count_q  <= '0;
            hw_q     <= '0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mcount_q <= mcount_d;
            count_q  <= count_d;
            hw_q     <= hw_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
        end
    end

    // Storage array is not reset; it is written only on an accepted word.
    always_ff @(posedge clk) begin
        if (reset_n && accept) begin
            mem[wr_ptr_q] <= in_if.data;
        end
    end
endmodule

// File: tb/tb_stream_fifo.sv
// tb/tb_stream_fifo.sv - directed self-checking bench for stream_fifo
module tb_stream_fifo;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // A: FWFT, DEPTH=4   B: FWFT, DEPTH=5   C: registered output, DEPTH=4
    stream_fifo_if #(.WIDTH(32)) a_in ();
    stream_fifo_if #(.WIDTH(32)) a_out ();
    stream_fifo_if #(.WIDTH(32)) b_in ();
    stream_fifo_if #(.WIDTH(32)) b_out ();
    stream_fifo_if #(.WIDTH(32)) c_in ();
    stream_fifo_if #(.WIDTH(32)) c_out ();

    logic       a_flush, a_hwc, b_flush, b_hwc, c_flush, c_hwc;
    logic [2:0] a_count, a_hw, b_count, b_hw, c_count, c_hw;
    logic       a_af, a_ae, b_af, b_ae, c_af, c_ae;

    stream_fifo #(.WIDTH(32), .DEPTH(4), .FWFT(1)) dut_a (
        .clk(clk), .reset_n(rst_n), .flush_i(a_flush), .hw_clear_i(a_hwc),
        .in_if(a_in), .out_if(a_out), .count_o(a_count), .high_water_o(a_hw),
        .almost_full_o(a_af), .almost_empty_o(a_ae)
    );
    stream_fifo #(.WIDTH(32), .DEPTH(5), .FWFT(1)) dut_b (
        .clk(clk), .reset_n(rst_n), .flush_i(b_flush), .hw_clear_i(b_hwc),
        .in_if(b_in), .out_if(b_out), .count_o(b_count), .high_water_o(b_hw),
        .almost_full_o(b_af), .almost_empty_o(b_ae)
    );
    stream_fifo #(.WIDTH(32), .DEPTH(4), .FWFT(0)) dut_c (
        .clk(clk), .reset_n(rst_n), .flush_i(c_flush), .hw_clear_i(c_hwc),
        .in_if(c_in), .out_if(c_out), .count_o(c_count), .high_water_o(c_hw),
        .almost_full_o(c_af), .almost_empty_o(c_ae)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp4 [4];
        rst_n = 1'b0;
        a_flush = 0; a_hwc = 0; b_flush = 0; b_hwc = 0; c_flush = 0; c_hwc = 0;
        a_in.valid = 0; a_in.data = '0; a_out.ready = 0;
        b_in.valid = 0; b_in.data = '0; b_out.ready = 0;
        c_in.valid = 0; c_in.data = '0; c_out.ready = 0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_a_count", a_count, 0);
        chk("rst_a_in_ready", a_in.ready, 1);
        chk("rst_a_out_valid", a_out.valid, 0);
        chk("rst_a_ae", a_ae, 1);
        chk("rst_a_af", a_af, 0);
        chk("rst_a_hw", a_hw, 0);
        chk("rst_c_out_valid", c_out.valid, 0);
        chk("rst_c_out_data", c_out.data, 0);

        // 1: fill A with A0..A3, hold off a 5th, then drain
        a_in.valid = 1;
        for (int i = 0; i < 4; i++) begin
            a_in.data = 32'hA0 + i;
            chk("t1_in_ready_fill", a_in.ready, 1);
            step();
        end
        chk("t1_count_full", a_count, 4);
        chk("t1_in_ready_full", a_in.ready, 0);
        chk("t1_af", a_af, 1);
        chk("t1_ae", a_ae, 0);
        a_in.data = 32'hA4;
        step();
        chk("t1_count_held", a_count, 4);
        a_in.valid = 0;
        a_out.ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("t1_out_valid", a_out.valid, 1);
            chk("t1_out_data", a_out.data, 32'hA0 + i);
            step();
        end
        a_out.ready = 0;
        chk("t1_count_empty", a_count, 0);
        chk("t1_out_valid_empty", a_out.valid, 0);
        chk("t1_hw", a_hw, 4);

        // 4: full with simultaneous push and pop
        a_in.valid = 1;
        for (int i = 0; i < 4; i++) begin
            a_in.data = 32'hB0 + i;
            step();
        end
        a_in.data = 32'hC0;
        a_out.ready = 1;
        chk("t4_in_ready_full", a_in.ready, 0);
        chk("t4_head", a_out.data, 32'hB0);
        step();
        chk("t4_count_after_pop", a_count, 3);
        chk("t4_in_ready_after_pop", a_in.ready, 1);
        chk("t4_head_after_pop", a_out.data, 32'hB1);
        a_out.ready = 0;
        step();
        chk("t4_count_after_accept", a_count, 4);
        a_in.valid = 0;
        a_out.ready = 1;
        exp4[0] = 32'hB1; exp4[1] = 32'hB2; exp4[2] = 32'hB3; exp4[3] = 32'hC0;
        for (int i = 0; i < 4; i++) begin
            chk("t4_drain", a_out.data, exp4[i]);
            step();
        end
        a_out.ready = 0;
        chk("t4_count_drained", a_count, 0);

        // 5: flush with count=3, then hw_clear; then flush+hw_clear together
        a_hwc = 1;
        step();
        a_hwc = 0;
        chk("t5_hw_cleared_empty", a_hw, 0);
        a_in.valid = 1;
        for (int i = 0; i < 3; i++) begin
            a_in.data = 32'hD0 + i;
            step();
        end
        chk("t5_count3", a_count, 3);
        chk("t5_hw3", a_hw, 3);
        a_in.data = 32'hD3;
        a_out.ready = 1;
        a_flush = 1;
        chk("t5_in_ready_during_flush", a_in.ready, 1);
        step();
        a_flush = 0;
        a_in.valid = 0;
        a_out.ready = 0;
        chk("t5_count_flushed", a_count, 0);
        chk("t5_out_valid_flushed", a_out.valid, 0);
        chk("t5_hw_kept", a_hw, 3);
        a_hwc = 1;
        step();
        a_hwc = 0;
        chk("t5_hw_clear", a_hw, 0);
        a_in.valid = 1;
        a_in.data = 32'hE0;
        step();
        a_in.data = 32'hE1;
        step();
        a_in.valid = 0;
        chk("t5_hw2", a_hw, 2);
        a_flush = 1;
        a_hwc = 1;
        step();
        a_flush = 0;
        a_hwc = 0;
        chk("t5_hw_flush_clear", a_hw, 0);
        chk("t5_count_flush_clear", a_count, 0);

        // 2: DEPTH=5 continuous stream of 20 words
        b_in.valid = 1;
        b_out.ready = 1;
        chk("t2_out_valid_initial", b_out.valid, 0);
        for (int i = 0; i < 20; i++) begin
            b_in.data = 32'hE00 + i;
            step();
            chk("t2_out_valid", b_out.valid, 1);
            chk("t2_out_data", b_out.data, 32'hE00 + i);
            chk("t2_count", b_count, 1);
        end
        b_in.valid = 0;
        step();
        b_out.ready = 0;
        chk("t2_count_end", b_count, 0);
        chk("t2_out_valid_end", b_out.valid, 0);
        chk("t2_hw", b_hw, 1);

        // 3: registered output mode
        c_in.valid = 1;
        c_in.data = 32'h11;
        step();
        c_in.valid = 0;
        chk("t3_out_valid_1edge", c_out.valid, 0);
        chk("t3_count_1edge", c_count, 1);
        step();
        chk("t3_out_valid_2edge", c_out.valid, 1);
        chk("t3_out_data_2edge", c_out.data, 32'h11);
        chk("t3_count_2edge", c_count, 1);
        c_in.valid = 1;
        for (int i = 1; i < 5; i++) begin
            c_in.data = 32'h11 + i;
            step();
        end
        c_in.valid = 0;
        chk("t3_count_cap", c_count, 5);
        chk("t3_in_ready_cap", c_in.ready, 0);
        chk("t3_af", c_af, 1);
        c_out.ready = 1;
        for (int i = 0; i < 5; i++) begin
            chk("t3_drain_valid", c_out.valid, 1);
            chk("t3_drain_data", c_out.data, 32'h11 + i);
            step();
        end
        c_out.ready = 0;
        chk("t3_out_valid_end", c_out.valid, 0);
        chk("t3_count_end", c_count, 0);
        chk("t3_data_retained", c_out.data, 32'h15);

        // 6: asynchronous reset between edges with count=2
        a_in.valid = 1;
        a_in.data = 32'hF0;
        step();
        a_in.data = 32'hF1;
        step();
        a_in.valid = 0;
        chk("t6_count_pre", a_count, 2);
        chk("t6_hw_pre", a_hw, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_count_async", a_count, 0);
        chk("t6_out_valid_async", a_out.valid, 0);
        chk("t6_hw_async", a_hw, 0);
        chk("t6_in_ready_async", a_in.ready, 1);
        step();
        rst_n = 1'b1;
        step();
        a_in.valid = 1;
        a_in.data = 32'h5A;
        step();
        a_in.valid = 0;
        chk("t6_out_valid_after", a_out.valid, 1);
        chk("t6_out_data_after", a_out.data, 32'h5A);
        chk("t6_count_after", a_count, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
- Parametrised successor to the team's single-clock push/pop FIFO.
- Uses a valid/ready streaming handshake on both sides, and supports any depth of 2 or more, including non-power-of-2.
- Output mode is selectable: first-word-fall-through, or registered output.
- Adds programmable almost-full/almost-empty thresholds, synchronous flush, and a high-water occupancy monitor.
- Sits between accelerator producers and consumers (weight/activation streams) wherever back-pressure buffering is needed.

Parameters:
WIDTH, 256, data word width in bits (>=1)
DEPTH, 4, storage entries in memory array (>=2, any integer)
FWFT, 1, 1 = head word presented combinationally from memory; 0 = head word held in an output register
AF_THRESH, DEPTH-1, almost_full asserts when count >= AF_THRESH
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all contents
in_valid  input  1  producer offers in_data
in_ready  output  1  FIFO accepts in_data this cycle
in_data  input  WIDTH  write data
out_valid  output  1  out_data holds valid head word
out_ready  input  1  consumer takes head word this cycle
out_data  output  WIDTH  head word
count  output  $clog2(CAP+1)  total occupancy, where CAP = DEPTH + (FWFT ? 0 : 1)
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
high_water  output  $clog2(CAP+1)  peak count since reset/hw_clear
hw_clear  input  1  synchronous reset of high_water to current count

Behaviour:
- Reset (reset_n low, asynchronous):
  - Pointers, count, out_valid, high_water and the output register all go to 0.
  - Therefore in_ready=1, almost_empty=1, almost_full=(AF_THRESH==0).
  - Memory contents are not reset.
  - Reset asserted mid-transfer discards everything; no handshake completes on that edge.
- Handshakes:
  - Accept occurs when in_valid && in_ready.
  - Pop occurs when out_valid && out_ready.
  - in_valid must not depend on in_ready, and out_ready must not depend on out_valid.
  - Data is captured only on an accept.
- in_ready = (memory occupancy < DEPTH), registered-equivalent. A full memory rejects a write even if a pop happens the same cycle; there is no pass-through when full.
- Pointers wrap DEPTH-1 -> 0 explicitly (compare, not modulo), so non-power-of-2 depths work.
- FWFT=1:
  - out_valid = (count != 0).
  - out_data = mem[r_ptr], valid whenever out_valid=1 and stable until popped.
  - Latency: a word accepted at edge N is visible at out_data after edge N, i.e. 1 cycle.
  - No same-cycle bypass when empty.
  - out_data is don't-care when out_valid=0.
- FWFT=0:
  - Adds a one-entry output register holding the head. out_valid is registered.
  - The register loads mem[r_ptr] when it is empty or being popped and memory holds at least 1 entry.
  - Latency in->out is 2 cycles.
  - out_data holds its value when out_valid=0 (it retains the last popped word).
  - Sustained throughput is 1 word/cycle with no bubbles once primed.
- Simultaneous accept + pop leaves count unchanged. Accept alone increments it; pop alone decrements it.
- count includes the output register in FWFT=0.
- almost_full and almost_empty are combinational from registered count. Thresholds outside 0..CAP are legal and simply saturate the flag constant.
- flush (synchronous, highest priority after reset):
  - Pointers, count and out_valid go to 0.
  - Any same-cycle accept or pop is ignored, and in_ready may still read 1 that cycle.
  - high_water is unaffected.
- high_water updates to count_next whenever count_next > high_water.
  - hw_clear loads count_next.
  - When hw_clear and flush coincide, high_water goes to 0.
- Elaboration check fails if DEPTH<2 or WIDTH<1.

Test Plan:
1. FWFT=1, DEPTH=4, WIDTH=32: push 0xA0..0xA3 back-to-back with out_ready=0 -> in_ready=0 after the 4th accept, count=4, almost_full=1. A 5th push 0xA4 is held off. Then pop 4 -> out_data sequence A0,A1,A2,A3, count=0, high_water=4.
2. DEPTH=5 (non-power-of-2), FWFT=1: stream 20 words with in_valid=out_ready=1 continuously -> output matches input order across 3+ pointer wraps, 1 word/cycle after the first-word latency of 1, count never exceeds 1.
3. FWFT=0, DEPTH=4: push 0x11 into empty -> out_valid rises 2 edges after accept. Then fill to count=5 (CAP) -> in_ready=0. Drain with out_ready=1 -> 5 words in order with no bubbles.
4. Full with simultaneous in_valid and out_ready -> pop occurs, accept rejected, count=DEPTH-1. The next cycle the accept succeeds.
5. Count=3, assert flush with in_valid=out_ready=1 -> next cycle count=0, out_valid=0, high_water still 3. Then hw_clear -> high_water=0.
6. Deassert reset_n asynchronously mid-stream (between edges) with count=2 -> out_valid, count and high_water go to 0 immediately, without waiting for a clock edge. After release, a push of 0x5A appears as the first output.
